// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV32I core: sequences the datapath enables and
// mux selects, and tracks a sticky illegal-opcode flag and a retired-instruction count.
module multicycle_control_unit #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    output logic                 pc_wr,
    output logic                 adr_src,
    output logic                 mem_wr,
    output logic                 ir_wr,
    output logic                 reg_wr,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_sel,
    output logic [3:0]           alu_ctrl,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JUMP, S_LUI, S_AUIPC
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_illegal;
    logic [CNT_WIDTH-1:0]   r_retired;
    logic                   w_set_illegal;
    logic                   w_retire;
    logic                   w_alt;
    logic [3:0]             w_funct_alu;
    logic [2:0]             w_imm_sel;

    assign illegal = r_illegal;
    assign retired = r_retired;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_retire)      r_retired <= r_retired + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        case (opcode)
            7'b0100011:             w_imm_sel = 3'b001;
            7'b1100011:             w_imm_sel = 3'b010;
            7'b0110111, 7'b0010111: w_imm_sel = 3'b011;
            7'b1101111:             w_imm_sel = 3'b100;
            default:                w_imm_sel = 3'b000;
        endcase
    end

    // funct7_5 selects SUB only for register ops; SRA/SRAI honour it in both forms
    assign w_alt = funct7_5 && ((funct3 == 3'b101) ||
                                (funct3 == 3'b000 && r_state == S_EXECR));

    always_comb begin
        case (funct3)
            3'b000:  w_funct_alu = w_alt ? ALU_SUB : ALU_ADD;
            3'b001:  w_funct_alu = ALU_SLL;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b011:  w_funct_alu = ALU_SLTU;
            3'b100:  w_funct_alu = ALU_XOR;
            3'b101:  w_funct_alu = w_alt ? ALU_SRA : ALU_SRL;
            3'b110:  w_funct_alu = ALU_OR;
            default: w_funct_alu = ALU_AND;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_retire      = 1'b0;
        pc_wr         = 1'b0;
        adr_src       = 1'b0;
        mem_wr        = 1'b0;
        ir_wr         = 1'b0;
        reg_wr        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_ctrl      = ALU_ADD;
        imm_sel       = w_imm_sel;
        case (r_state)
            S_FETCH: begin
                ir_wr      = 1'b1;
                pc_wr      = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JUMP;
                    7'b1100111:             w_next = S_JALR;
                    7'b0110111:             w_next = S_LUI;
                    7'b0010111:             w_next = S_AUIPC;
                    default: begin
                        w_next        = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_wr     = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src  = 1'b1;
                mem_wr   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = w_funct_alu;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = w_funct_alu;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                w_next    = S_FETCH;
                // only BEQ/BNE are supported; anything else is flagged and not retired
                if (funct3[2:1] == 2'b00) begin
                    pc_wr    = zero ^ funct3[0];
                    w_retire = 1'b1;
                end else begin
                    w_set_illegal = 1'b1;
                end
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = S_JUMP;
            end
            S_JUMP: begin
                pc_wr     = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_PASSB;
                w_next    = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                w_next    = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
        if (!reset) begin
            pc_wr      = 1'b0;
            adr_src    = 1'b0;
            mem_wr     = 1'b0;
            ir_wr      = 1'b0;
            reg_wr     = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            imm_sel    = 3'b000;
            alu_ctrl   = ALU_ADD;
        end
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Control FSM for the multicycle RV32I core. It consumes the latched instruction fields and the ALU zero flag from the datapath, and drives every enable and mux select of that datapath:
- PC register enable
- address mux
- memory write
- IR/OldPC enable
- register-file write
- SrcA/SrcB muxes
- result mux
- immediate selector
- ALU operation

It also keeps a sticky illegal-opcode flag and a retired-instruction counter.

## Interface
- `CNT_WIDTH`, 32, width of retired-instruction counter
- `clk` in 1, core clock, all state updates on rising edge
- `reset` in 1, synchronous, active-low
- `opcode` in 7, `Instruction[6:0]`
- `funct3` in 3, `Instruction[14:12]`
- `funct7_5` in 1, `Instruction[30]`
- `zero` in 1, ALU zero flag (combinational from current SrcA/SrcB)
- `pc_wr` out 1, PC register enable
- `adr_src` out 1, 0 = PC, 1 = ALUOut register
- `mem_wr` out 1, data memory write
- `ir_wr` out 1, IR and OldPC enable
- `reg_wr` out 1, register-file write
- `alu_src_a` out 2, 00 = PC, 01 = OldPC, 10 = rs1 register
- `alu_src_b` out 2, 00 = rs2 register, 01 = imm, 10 = constant 4
- `result_src` out 2, 00 = ALUOut register, 01 = Data register, 10 = ALU result
- `imm_sel` out 3, 000 I, 001 S, 010 B, 011 U, 100 J
- `alu_ctrl` out 4, 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB
- `illegal` out 1, sticky illegal-instruction flag
- `retired` out `CNT_WIDTH`, instructions completed since reset

## Operation
- **Output decoding**
  - Outputs are combinational from the current state; `pc_wr` additionally depends on `zero` in BRANCH.
  - Every output not listed for a state is 0.
- **`imm_sel`**: combinational from `opcode` in all states.
  - 0100011 → S; 1100011 → B; 1101111 → J; 0110111/0010111 → U; otherwise I.
- **States and transitions** (state register updates on `clk`):
  - FETCH: `ir_wr`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10, `pc_wr`=1 → DECODE.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, ADD (branch/JAL target into ALUOut). Next state by opcode:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JUMP
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - else → FETCH and set `illegal`
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, ADD → MEMREAD if opcode 0000011, else MEMWRITE.
  - MEMREAD: `adr_src`=1, `result_src`=00 → MEMWB.
  - MEMWB: `result_src`=01, `reg_wr`=1 → FETCH.
  - MEMWRITE: `adr_src`=1, `result_src`=00, `mem_wr`=1 → FETCH.
  - EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_ctrl` from {`funct7_5`, `funct3`} → ALUWB.
  - EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_ctrl` from `funct3`; `funct7_5` is honoured only for `funct3`=101 (SRAI) → ALUWB.
  - ALUWB: `result_src`=00, `reg_wr`=1 → FETCH.
  - BRANCH: `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00; `pc_wr` = `zero` XOR `funct3[0]` → FETCH.
    - `funct3` ∉ {000, 001}: `pc_wr`=0 and `illegal` is set.
  - JALR: `alu_src_a`=10, `alu_src_b`=01, ADD → JUMP.
  - JUMP: `result_src`=00, `pc_wr`=1, `alu_src_a`=01, `alu_src_b`=10, ADD (link value into ALUOut) → ALUWB.
  - LUI: `alu_src_b`=01, PASSB → ALUWB.
  - AUIPC: `alu_src_a`=01, `alu_src_b`=01, ADD → ALUWB.
- **Funct mapping** (R-type; I-type identical except SUB is never selected):
  - 000 ADD (SUB if `funct7_5`)
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101 SRL (SRA if `funct7_5`)
  - 110 OR, 111 AND
- **`retired`**
  - Increments by 1 on every clock edge leaving MEMWB, MEMWRITE, ALUWB, or BRANCH.
  - Wraps modulo 2^`CNT_WIDTH`.
  - Illegal instructions do not count.

## Timing
- **Reset**: while `reset`=0 at an edge, the state becomes FETCH, `illegal` becomes 0 and `retired` becomes 0.
  - While `reset` is low, all enables (`pc_wr`, `mem_wr`, `ir_wr`, `reg_wr`) are forced to 0 and all selects to 0.
  - Reset asserted mid-instruction aborts it without a write.
- **Cycles per instruction**:
  - lw 5; jalr 5
  - sw, R, I, jal, lui, auipc 4
  - branch 3; illegal 2
- `illegal` sets on the edge leaving DECODE (or BRANCH) and holds until reset.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles with `opcode`=0110011 → all enables 0, `retired`=0, `illegal`=0. Release → first cycle shows `ir_wr`=1, `pc_wr`=1, `alu_src_b`=10.
- **ADDI** (0x00500093): FETCH, DECODE, EXECI (`alu_ctrl`=0, `imm_sel`=000), ALUWB (`reg_wr`=1) → `retired`=1 after 4 cycles.
- **LW and SW**: LW (0x0000A103) → MEMREAD with `adr_src`=1, MEMWB with `result_src`=01, `reg_wr`=1, 5 cycles. SW (0x0020A023) → `mem_wr`=1 in cycle 4 only, `imm_sel`=001.
- **BEQ/BNE**: BEQ (`funct3`=000) with `zero`=1 → `pc_wr`=1 in cycle 3; `zero`=0 → `pc_wr`=0. BNE inverts both; `retired` increments in every case.
- **JAL/JALR**: JAL (0x008000EF) → JUMP with `pc_wr`=1, `result_src`=00, then ALUWB, `imm_sel`=100. JALR (0x000080E7) → JALR, JUMP, ALUWB, 5 cycles total.
- **Illegal and wrap**:
  - Opcode 0x7F → back to FETCH after 2 cycles, `illegal`=1, `retired` unchanged.
  - `illegal` stays 1 across 10 further legal instructions.
  - Branch with `funct3`=010 → `pc_wr`=0, `illegal`=1.
  - With `CNT_WIDTH`=4, 16 retired instructions → `retired` wraps to 0.
